clint_timer: RTL
================

Name: clint_timer

Overview:
Parametrised machine-timer/software-interrupt block (CLINT-style) for the RV32 cores. It replaces the fixed single mtime/mtimecmp pair with a configurable number of harts, a tick prescaler, and per-hart MSIP registers. It sits on the core data-memory path: the core raises a word request, `hit_o` tells the core to suppress the RAM access, and read data returns one cycle later. It drives `mtip_o`/`msip_o` into each hart's CSR/exception unit.

Parameters:
N_HARTS, 1, number of harts; one mtimecmp and one msip per hart (1..16)
BASE_ADDR, 32'h0200_0000, base of the 64 KiB register window
TICK_DIV, 1, mtime increments once every TICK_DIV clk cycles (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_i  in  1  word access request (single cycle)
we_i  in  1  1=store, 0=load; valid with req_i
addr_i  in  32  byte address; bits[1:0] ignored
wdata_i  in  32  store data
hit_o  out  1  combinational: req_i and addr_i decodes to a mapped register
rdata_o  out  32  load data, valid when rvalid_o
rvalid_o  out  1  one-cycle pulse, cycle after a load hit
mtip_o  out  N_HARTS  registered timer-interrupt pending per hart
msip_o  out  N_HARTS  software-interrupt pending per hart (msip[h] bit0)

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Register map, offsets from BASE_ADDR:
  - MSIP[h]: 0x0000+4h.
  - MTIMECMP[h] low/high: 0x4000+8h / 0x4004+8h.
  - MTIME low/high: 0xBFF8 / 0xBFFC.
  - Any other offset, or h>=N_HARTS: hit_o=0; no side effects; the core routes the access to RAM.
- Reset values:
  - mtime: 0.
  - mtimecmp[h]: 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt out of reset.
  - msip: 0; mtip_o: 0; rdata_o: 0; rvalid_o: 0.
  - Prescaler count: 0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick asserts on the cycle count==TICK_DIV-1, then count wraps to 0.
  - TICK_DIV=1 means tick every cycle.
- mtime:
  - Adds 1 on tick; 64-bit wrap from all-ones to 0.
  - A store hit to MTIME low or high writes that half with wdata_i and suppresses the increment that cycle. The other half is unchanged and there is no carry.
  - The prescaler keeps counting during a write.
- mtimecmp: store writes the addressed 32-bit half only.
- MSIP store: only wdata_i[0] is stored; reads return {31'b0, msip[h]}.
- Loads:
  - rdata_o/rvalid_o are registered, latency 1.
  - rdata_o returns the value before any same-cycle update (tick or write).
  - rdata_o holds its last value when rvalid_o=0.
  - Stores never assert rvalid_o.
- mtip_o[h]: registered `mtime >= mtimecmp[h]`, unsigned 64-bit, evaluated on post-update values. It therefore rises the cycle after mtime reaches mtimecmp, or the cycle after a write makes the compare true. It clears the same way.
- Simultaneous events: a write to mtime and a tick in the same cycle: the write wins and the tick is lost. Only one request can be issued per cycle.
- Reset mid-operation: a pending rvalid_o is dropped; all state returns to its reset values.

Optional Feature:
- Macro: CLINT_SNAPSHOT_EN.
- Defined: a load of MTIME low also latches mtime[63:32] into a shadow register. A load of MTIME high returns the shadow, giving an atomic 64-bit read across two loads. Shadow reset value is 0. Stores to MTIME high also update the shadow.
- Undefined: no shadow; MTIME high returns live mtime[63:32]. Software uses the hi/lo/hi retry loop.

Decomposition:
- Shared package Common:
  - Offsets CLINT_MSIP_OFF, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF.
  - CLINT_WINDOW_SIZE.
  - `typedef logic [63:0] uint64`.
  - An enum clint_reg_t {CLINT_MSIP, CLINT_CMP_LO, CLINT_CMP_HI, CLINT_MTIME_LO, CLINT_MTIME_HI, CLINT_NONE} returned by a package decode function.
- Sub-module clint_prescaler (params TICK_DIV; ports clk, rst, tick_o).

Test Plan:
- Reset then idle, TICK_DIV=1 → mtime reads 10 after 10 cycles; all mtip_o=0; load of 0xBFF8 returns data with rvalid_o exactly 1 cycle later.
- TICK_DIV=4 → mtime=3 after 12 cycles; a load of MTIME on a tick cycle returns the pre-increment value.
- N_HARTS=2, write mtimecmp[1]=20 (low 20, high 0), mtime running → mtip_o=2'b10 the cycle after mtime==20; mtip_o[0] stays 0. Rewriting cmp high=1 clears mtip_o[1] next cycle.
- Write mtime low=32'hFFFF_FFFF, high=32'hFFFF_FFFF → the next tick gives mtime=0; a write coinciding with a tick leaves exactly the written value.
- Store 0x1 to MSIP[1] → msip_o=2'b10; read back 1; store 0xFFFF_FFFE → 0. Access to offset 0x0008 with N_HARTS=2, or 0x8000 → hit_o=0, no state change.
- CLINT_SNAPSHOT_EN: mtime=0x0000_0000_FFFF_FFFF, read low, tick carries, read high → high returns 0; without the macro it returns 1.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: shared definitions for the CLINT-style machine timer.
//   - register window geometry and register offsets
//   - uint64 type used for mtime / mtimecmp
//   - clint_reg_t register selector and the address decode helpers
// Decode helpers take the word index inside the 64 KiB window (byte offset >> 2)
// so byte-lane bits never reach them.

package clint_timer_pkg;

  typedef logic [63:0] uint64;

  localparam int unsigned CLINT_WINDOW_SIZE  = 32'h0001_0000;
  localparam int          CLINT_WINDOW_BITS  = 16;
  localparam int          CLINT_MAX_HARTS    = 16;
  localparam int          CLINT_PRESCALE_W   = 16;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [2:0] {
    CLINT_MSIP,
    CLINT_CMP_LO,
    CLINT_CMP_HI,
    CLINT_MTIME_LO,
    CLINT_MTIME_HI,
    CLINT_NONE
  } clint_reg_t;

  // MSIP occupies words 0..15, MTIMECMP 16 doublewords from 0x4000, MTIME the
  // last doubleword below 0xC000. Slots for harts that do not exist decode to
  // CLINT_NONE so the core sends those accesses to RAM.
  function automatic clint_reg_t clint_decode(input logic [13:0] word, input int n_harts);
    clint_reg_t sel;
    sel = CLINT_NONE;
    if (word[13:4] == CLINT_MSIP_OFF[15:6]) begin
      if (int'({28'b0, word[3:0]}) < n_harts) sel = CLINT_MSIP;
    end else if (word[13:5] == CLINT_MTIMECMP_OFF[15:7]) begin
      if (int'({28'b0, word[4:1]}) < n_harts) sel = word[0] ? CLINT_CMP_HI : CLINT_CMP_LO;
    end else if (word[13:1] == CLINT_MTIME_OFF[15:3]) begin
      sel = word[0] ? CLINT_MTIME_HI : CLINT_MTIME_LO;
    end
    return sel;
  endfunction

  // Hart index of a per-hart register; meaningless for MTIME / CLINT_NONE.
  function automatic logic [3:0] clint_hart(input logic [13:0] word, input clint_reg_t sel);
    return (sel == CLINT_MSIP) ? word[3:0] : word[4:1];
  endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// clint_prescaler: divides clk down to the mtime increment strobe.
//   clk    : clock
//   rst    : synchronous, active-high reset (count returns to 0)
//   tick_o : high for one cycle when count == TICK_DIV-1; count then wraps to 0
// TICK_DIV = 1 gives a tick every cycle (count stays at 0).

module clint_prescaler
  import clint_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam logic [CLINT_PRESCALE_W-1:0] LAST = CLINT_PRESCALE_W'(TICK_DIV - 1);

  logic [CLINT_PRESCALE_W-1:0] count;

  assign tick_o = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick_o) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT-style machine timer / software interrupt block.
// Sits on the core data-memory path; a hit suppresses the RAM access and load
// data returns one cycle later.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_i, we_i         : single-cycle word request, 1 = store
//   addr_i, wdata_i     : byte address (bits [1:0] ignored), store data
//   hit_o               : combinational, request decodes to a mapped register
//   rdata_o, rvalid_o   : registered load data and its one-cycle valid pulse
//   mtip_o, msip_o      : per-hart timer / software interrupt pending
// Optional feature macro CLINT_SNAPSHOT_EN: a load of MTIME low captures
// mtime[63:32] into a shadow that a later load of MTIME high returns, giving
// an atomic 64-bit read. Without it MTIME high reads the live value.

module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int          N_HARTS   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               hit_o,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic [N_HARTS-1:0] mtip_o,
  output logic [N_HARTS-1:0] msip_o
);

  logic        tick;
  logic        in_window;
  logic [13:0] word;
  logic        addr_unused;
  clint_reg_t  reg_sel;
  logic [3:0]  hart;
  logic        load_hit;
  logic        store_hit;

  uint64 mtime;
  uint64 mtime_next;
  uint64 cmp      [N_HARTS];
  uint64 cmp_next [N_HARTS];

  logic [N_HARTS-1:0] msip;
  logic [N_HARTS-1:0] msip_next;
  logic [N_HARTS-1:0] mtip;
  logic [N_HARTS-1:0] mtip_next;

  logic [31:0] read_mux;
  logic [31:0] rdata;
  logic        rvalid;

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] shadow;
`endif

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // Address decode; byte-lane bits carry no meaning for word accesses.
  assign addr_unused = ^addr_i[1:0];
  assign in_window   = (addr_i[31:CLINT_WINDOW_BITS] == BASE_ADDR[31:CLINT_WINDOW_BITS]);
  assign word        = addr_i[CLINT_WINDOW_BITS-1:2];
  assign reg_sel     = in_window ? clint_decode(word, N_HARTS) : CLINT_NONE;
  assign hart        = clint_hart(word, reg_sel);
  assign hit_o       = req_i && (reg_sel != CLINT_NONE);
  assign load_hit    = hit_o && !we_i;
  assign store_hit   = hit_o && we_i;

  // A store to either mtime half replaces that half and swallows any tick in
  // the same cycle; no carry crosses between halves on a write.
  always_comb begin
    mtime_next = mtime;
    if (store_hit && reg_sel == CLINT_MTIME_LO) begin
      mtime_next = {mtime[63:32], wdata_i};
    end else if (store_hit && reg_sel == CLINT_MTIME_HI) begin
      mtime_next = {wdata_i, mtime[31:0]};
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  // Per-hart register updates. The interrupt compare uses the post-update
  // mtime and mtimecmp so mtip follows a write or tick by exactly one cycle.
  always_comb begin
    for (int h = 0; h < N_HARTS; h++) begin
      cmp_next[h]  = cmp[h];
      msip_next[h] = msip[h];
      if (store_hit && hart == 4'(h)) begin
        case (reg_sel)
          CLINT_CMP_LO: cmp_next[h]  = {cmp[h][63:32], wdata_i};
          CLINT_CMP_HI: cmp_next[h]  = {wdata_i, cmp[h][31:0]};
          CLINT_MSIP:   msip_next[h] = wdata_i[0];
          default:      ;
        endcase
      end
      mtip_next[h] = (mtime_next >= cmp_next[h]);
    end
  end

  // Load data is taken from the current (pre-update) register values.
  always_comb begin
    read_mux = '0;
    case (reg_sel)
      CLINT_MSIP: begin
        for (int h = 0; h < N_HARTS; h++) begin
          if (hart == 4'(h)) read_mux = {31'b0, msip[h]};
        end
      end
      CLINT_CMP_LO: begin
        for (int h = 0; h < N_HARTS; h++) begin
          if (hart == 4'(h)) read_mux = cmp[h][31:0];
        end
      end
      CLINT_CMP_HI: begin
        for (int h = 0; h < N_HARTS; h++) begin
          if (hart == 4'(h)) read_mux = cmp[h][63:32];
        end
      end
      CLINT_MTIME_LO: read_mux = mtime[31:0];
`ifdef CLINT_SNAPSHOT_EN
      CLINT_MTIME_HI: read_mux = shadow;
`else
      CLINT_MTIME_HI: read_mux = mtime[63:32];
`endif
      default: read_mux = '0;
    endcase
  end

  // Architectural state. mtimecmp resets to all-ones so nothing fires out of
  // reset; a reset in the load cycle drops the pending rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime  <= '0;
      msip   <= '0;
      mtip   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      for (int h = 0; h < N_HARTS; h++) begin
        cmp[h] <= '1;
      end
    end else begin
      mtime  <= mtime_next;
      msip   <= msip_next;
      mtip   <= mtip_next;
      rvalid <= load_hit;
      if (load_hit) begin
        rdata <= read_mux;
      end
      for (int h = 0; h < N_HARTS; h++) begin
        cmp[h] <= cmp_next[h];
      end
    end
  end

`ifdef CLINT_SNAPSHOT_EN
  // Shadow of the upper mtime half, captured with the value a low load sees so
  // the pair of loads is consistent even if the low half carries in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (load_hit && reg_sel == CLINT_MTIME_LO) begin
      shadow <= mtime[63:32];
    end else if (store_hit && reg_sel == CLINT_MTIME_HI) begin
      shadow <= wdata_i;
    end
  end
`endif

  assign rdata_o  = rdata;
  assign rvalid_o = rvalid;
  assign mtip_o   = mtip;
  assign msip_o   = msip;

endmodule
